id_ex_operand_stage: RTL

- ID/EX pipeline stage directly downstream of the 32-entry register file.
- Captures read_data1/read_data2, resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards.
- On a load-use hazard it inserts one bubble and stalls PC and IF/ID.
- Presents registered operands and control to the EX stage, and counts stall cycles.

---
 rtl/id_ex_operand_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM/WB results onto the decode operands,
// inserts a one-cycle bubble on load-use hazards and counts stall cycles.
module id_ex_operand_stage #(
  parameter int n     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [n-1:0]     id_imm,
  input  logic [n-1:0]     id_pc,
  input  logic [n-1:0]     rf_read_data1,
  input  logic [n-1:0]     rf_read_data2,
  input  logic [n-1:0]     ex_alu_result,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [n-1:0]     mem_result,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [n-1:0]     wb_result,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [n-1:0]     ex_rs1_data,
  output logic [n-1:0]     ex_rs2_data,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic [n-1:0]     ex_imm,
  output logic [n-1:0]     ex_pc,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             r_ex_valid;
  logic [n-1:0]     r_ex_rs1_data;
  logic [n-1:0]     r_ex_rs2_data;
  logic [4:0]       r_ex_rd;
  logic             r_ex_reg_write;
  logic             r_ex_mem_read;
  logic [n-1:0]     r_ex_imm;
  logic [n-1:0]     r_ex_pc;
  logic [CNT_W-1:0] r_stall_cycles;

  logic             w_ex_fwd_ok;
  logic             w_ex_hit1, w_mem_hit1, w_wb_hit1;
  logic             w_ex_hit2, w_mem_hit2, w_wb_hit2;
  logic [n-1:0]     w_fwd1, w_fwd2;
  logic             w_hz;
  logic             w_kill;

  // A load in EX has no value yet, so it never forwards from EX.
  assign w_ex_fwd_ok = r_ex_valid & r_ex_reg_write & ~r_ex_mem_read;

  assign w_ex_hit1  = w_ex_fwd_ok   & (r_ex_rd == id_rs1) & (id_rs1 != 5'd0);
  assign w_mem_hit1 = mem_reg_write & (mem_rd  == id_rs1) & (id_rs1 != 5'd0);
  assign w_wb_hit1  = wb_reg_write  & (wb_rd   == id_rs1) & (id_rs1 != 5'd0);
  assign w_ex_hit2  = w_ex_fwd_ok   & (r_ex_rd == id_rs2) & (id_rs2 != 5'd0);
  assign w_mem_hit2 = mem_reg_write & (mem_rd  == id_rs2) & (id_rs2 != 5'd0);
  assign w_wb_hit2  = wb_reg_write  & (wb_rd   == id_rs2) & (id_rs2 != 5'd0);

  assign w_fwd1 = (id_rs1 == 5'd0) ? '0            :
                  w_ex_hit1        ? ex_alu_result :
                  w_mem_hit1       ? mem_result    :
                  w_wb_hit1        ? wb_result     : rf_read_data1;

  assign w_fwd2 = (id_rs2 == 5'd0) ? '0            :
                  w_ex_hit2        ? ex_alu_result :
                  w_mem_hit2       ? mem_result    :
                  w_wb_hit2        ? wb_result     : rf_read_data2;

  assign w_hz = id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == r_ex_rd)) |
                 (id_uses_rs2 & (id_rs2 == r_ex_rd)));

  assign stall  = w_hz & ~flush;
  assign w_kill = flush | w_hz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs1_data  <= '0;
      r_ex_rs2_data  <= '0;
      r_ex_rd        <= 5'd0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_imm       <= '0;
      r_ex_pc        <= '0;
      r_stall_cycles <= '0;
    end else begin
      // Data fields load unconditionally; only the control bits are squashed.
      r_ex_rs1_data <= w_fwd1;
      r_ex_rs2_data <= w_fwd2;
      r_ex_rd       <= id_rd;
      r_ex_imm      <= id_imm;
      r_ex_pc       <= id_pc;
      if (w_kill) begin
        r_ex_valid     <= 1'b0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
      end else begin
        r_ex_valid     <= id_valid;
        r_ex_reg_write <= id_valid & id_reg_write;
        r_ex_mem_read  <= id_valid & id_mem_read;
      end
      if (stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_rs1_data  = r_ex_rs1_data;
  assign ex_rs2_data  = r_ex_rs2_data;
  assign ex_rd        = r_ex_rd;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_imm       = r_ex_imm;
  assign ex_pc        = r_ex_pc;
  assign stall_cycles = r_stall_cycles;

endmodule
